vend_ctrl: RTL and testbench

Parametrised successor to the single-machine beverage FSM. It accepts coins of legal denominations, sells one of `NPROD` products at runtime-programmable prices, and waits a cycle-counted dispense delay before presenting the product. It also returns change under a selectable policy and supports user cancel. All delays are counter-based with no `#` delays. Products and change leave through valid/ack handshakes, so the block drives real dispenser actuators.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_ctrl_if.sv | 33 +++
 rtl/vend_timer.sv | 37 +++
 rtl/vend_ctrl.sv | 139 +++++++++++++
 tb/tb_vend_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller: FSM states, legal coin
// denominations and small combinational utilities.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BEV,
    VEND,
    WAIT_CHG,
    PAY_CHG
  } state_e;

  localparam logic [31:0] COIN_10  = 32'd10;
  localparam logic [31:0] COIN_20  = 32'd20;
  localparam logic [31:0] COIN_50  = 32'd50;
  localparam logic [31:0] COIN_100 = 32'd100;
  localparam logic [31:0] COIN_200 = 32'd200;

  function automatic logic is_legal_coin(input logic [31:0] value);
    return (value == COIN_10) || (value == COIN_20) || (value == COIN_50) ||
           (value == COIN_100) || (value == COIN_200);
  endfunction

  // Pairwise minimum; folded across the price table to find the cheapest product.
  function automatic logic [31:0] min_price(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Customer-facing and actuator-facing signals of vend_ctrl. The master side
// (coin acceptor, keypad, dispensers) drives requests and acks; the slave is the controller.
interface vend_ctrl_if #(
  parameter int CW    = 16,
  parameter int NPROD = 4,
  parameter int SW    = (NPROD > 1) ? $clog2(NPROD) : 1
);
  logic                  coin_valid;
  logic [CW-1:0]         coin;
  logic                  sel_valid;
  logic [SW-1:0]         sel;
  logic                  cancel;
  logic [NPROD*CW-1:0]   price;
  logic                  coin_reject;
  logic                  bev_valid;
  logic [SW-1:0]         bev;
  logic                  bev_ack;
  logic                  chg_valid;
  logic [CW-1:0]         chg;
  logic                  chg_ack;
  logic [CW-1:0]         credit;
  logic                  busy;

  modport master (
    output coin_valid, coin, sel_valid, sel, cancel, price, bev_ack, chg_ack,
    input  coin_reject, bev_valid, bev, chg_valid, chg, credit, busy
  );

  modport slave (
    input  coin_valid, coin, sel_valid, sel, cancel, price, bev_ack, chg_ack,
    output coin_reject, bev_valid, bev, chg_valid, chg, credit, busy
  );
endinterface

// File: rtl/vend_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Shared by the dispense delay and the change delay.
module vend_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: reset is synchronous and active-low, so it is sampled inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: accumulates legal coins, vends one of NPROD products at
// programmable prices after a dispense delay, and returns change through a handshake.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CW         = 16,
  parameter int NPROD      = 4,
  parameter int DISP_CYC   = 10,
  parameter int CHG_CYC    = 20,
  parameter int MAX_CREDIT = 500,
  parameter int AUTO_CHG   = 0
) (
  input  logic       clk,
  input  logic       rst,
  vend_ctrl_if.slave bus
);

  localparam int SW   = (NPROD > 1) ? $clog2(NPROD) : 1;
  localparam int TMAX = (DISP_CYC > CHG_CYC) ? DISP_CYC : CHG_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [CW:0] MAX_C = (CW + 1)'(MAX_CREDIT);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] lprice_q, lprice_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          coin_reject_q, coin_reject_d;

  logic          tmr_load, tmr_done, tmr_count;
  logic [TW-1:0] tmr_val;
  logic          sel_hit, coin_ok, give_chg;
  logic [CW-1:0] sel_price, cheapest, residual;
  logic [CW:0]   coin_sum;
  logic [31:0]   min_acc;

  always_comb begin
    sel_hit   = 1'b0;
    sel_price = '0;
    min_acc   = 32'(bus.price[CW-1:0]);
    for (int i = 0; i < NPROD; i++) begin
      if (bus.sel == SW'(i)) begin
        sel_hit   = 1'b1;
        sel_price = bus.price[i*CW +: CW];
      end
      min_acc = min_price(min_acc, 32'(bus.price[i*CW +: CW]));
    end
    cheapest = CW'(min_acc);
  end

  // Extra bit so an overflowing sum is still caught by the ceiling compare.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, bus.coin};
  assign residual  = credit_q - lprice_q;
  assign give_chg  = (AUTO_CHG != 0) ? (residual != '0)
                                     : ((residual != '0) && (residual < cheapest));
  assign tmr_count = (state_q == WAIT_BEV) || (state_q == WAIT_CHG);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    lprice_d = lprice_q;
    sel_d    = sel_q;
    coin_ok  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = TW'(CHG_CYC - 1);
    unique case (state_q)
      IDLE: begin
        if (bus.cancel && (credit_q != '0)) begin
          state_d  = WAIT_CHG;
          tmr_load = 1'b1;
        end else if (bus.sel_valid && sel_hit && (credit_q >= sel_price)) begin
          state_d  = WAIT_BEV;
          sel_d    = bus.sel;
          lprice_d = sel_price;
          tmr_load = 1'b1;
          tmr_val  = TW'(DISP_CYC - 1);
        end else if (bus.coin_valid && is_legal_coin(32'(bus.coin)) && (coin_sum <= MAX_C)) begin
          coin_ok  = 1'b1;
          credit_d = coin_sum[CW-1:0];
        end
      end
      WAIT_BEV: if (tmr_done) state_d = VEND;
      VEND: begin
        if (bus.bev_ack) begin
          credit_d = residual;
          if (give_chg) begin
            state_d  = WAIT_CHG;
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_CHG: if (tmr_done) state_d = PAY_CHG;
      PAY_CHG: begin
        if (bus.chg_ack) begin
          credit_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    coin_reject_d = bus.coin_valid && !coin_ok;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      lprice_q      <= '0;
      sel_q         <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      lprice_q      <= lprice_d;
      sel_q         <= sel_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  vend_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  assign bus.coin_reject = coin_reject_q;
  assign bus.bev_valid   = (state_q == VEND);
  assign bus.bev         = (state_q == VEND) ? sel_q : '0;
  assign bus.chg_valid   = (state_q == PAY_CHG);
  assign bus.chg         = (state_q == PAY_CHG) ? credit_q : '0;
  assign bus.credit      = credit_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: two instances (AUTO_CHG=0 and AUTO_CHG=1) checked against a
// transaction-level credit model, directed scenarios followed by randomized traffic.
module tb_vend_ctrl;

  localparam int CW       = 16;
  localparam int NPROD    = 4;
  localparam int SW       = 2;
  localparam int DISP_CYC = 10;
  localparam int CHG_CYC  = 20;
  localparam int MAXC     = 500;

  logic                clk;
  logic                rst;
  logic [1:0]          coin_valid, sel_valid, cancel, bev_ack, chg_ack;
  logic [CW-1:0]       coin [2];
  logic [SW-1:0]       sel [2];
  logic [NPROD*CW-1:0] price_vec;
  logic [1:0]          coin_reject, bev_valid, chg_valid, busy;
  logic [SW-1:0]       bev [2];
  logic [CW-1:0]       chg [2];
  logic [CW-1:0]       credit [2];

  int n_cmp = 0;
  int n_bad = 0;
  int m_credit [2];
  int prices [NPROD];
  int legal_tbl [5] = '{10, 20, 50, 100, 200};
  int coin_tbl [10] = '{10, 20, 50, 100, 200, 5, 30, 0, 15, 250};

  vend_ctrl_if #(.CW(CW), .NPROD(NPROD)) bus0 ();
  vend_ctrl_if #(.CW(CW), .NPROD(NPROD)) bus1 ();

  assign bus0.coin_valid = coin_valid[0];  assign bus1.coin_valid = coin_valid[1];
  assign bus0.coin       = coin[0];        assign bus1.coin       = coin[1];
  assign bus0.sel_valid  = sel_valid[0];   assign bus1.sel_valid  = sel_valid[1];
  assign bus0.sel        = sel[0];         assign bus1.sel        = sel[1];
  assign bus0.cancel     = cancel[0];      assign bus1.cancel     = cancel[1];
  assign bus0.price      = price_vec;      assign bus1.price      = price_vec;
  assign bus0.bev_ack    = bev_ack[0];     assign bus1.bev_ack    = bev_ack[1];
  assign bus0.chg_ack    = chg_ack[0];     assign bus1.chg_ack    = chg_ack[1];
  assign coin_reject[0]  = bus0.coin_reject; assign coin_reject[1] = bus1.coin_reject;
  assign bev_valid[0]    = bus0.bev_valid;   assign bev_valid[1]   = bus1.bev_valid;
  assign bev[0]          = bus0.bev;         assign bev[1]         = bus1.bev;
  assign chg_valid[0]    = bus0.chg_valid;   assign chg_valid[1]   = bus1.chg_valid;
  assign chg[0]          = bus0.chg;         assign chg[1]         = bus1.chg;
  assign credit[0]       = bus0.credit;      assign credit[1]      = bus1.credit;
  assign busy[0]         = bus0.busy;        assign busy[1]        = bus1.busy;

  vend_ctrl #(.CW(CW), .NPROD(NPROD), .DISP_CYC(DISP_CYC), .CHG_CYC(CHG_CYC),
              .MAX_CREDIT(MAXC), .AUTO_CHG(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  vend_ctrl #(.CW(CW), .NPROD(NPROD), .DISP_CYC(DISP_CYC), .CHG_CYC(CHG_CYC),
              .MAX_CREDIT(MAXC), .AUTO_CHG(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic bit is_legal(input int v);
    foreach (legal_tbl[i]) if (legal_tbl[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int cheapest();
    int m = prices[0];
    for (int i = 1; i < NPROD; i++) if (prices[i] < m) m = prices[i];
    return m;
  endfunction

  task automatic load_prices(input int p0, input int p1, input int p2, input int p3);
    prices = '{p0, p1, p2, p3};
    for (int i = 0; i < NPROD; i++) price_vec[i*CW +: CW] = CW'(prices[i]);
  endtask

  // Change handshake, entered right after the edge that decided to return change.
  task automatic finish_chg(input int d, input int hold);
    int n = 0;
    while (chg_valid[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != CHG_CYC) begin
      n_bad++;
      $display("FAIL chg_latency[%0d]: got %0d cycles, want %0d", d, n, CHG_CYC);
    end
    for (int i = 0; i <= hold; i++) begin
      n_cmp++;
      if (chg_valid[d] !== 1'b1 || chg[d] !== CW'(m_credit[d])) begin
        n_bad++;
        $display("FAIL chg_hold[%0d]: valid=%b chg=%0d, want valid=1 chg=%0d", d, chg_valid[d], chg[d], m_credit[d]);
      end
      if (i < hold) @(negedge clk);
    end
    chg_ack[d] = 1'b1;
    @(negedge clk);
    chg_ack[d] = 1'b0;
    m_credit[d] = 0;
    n_cmp++;
    if (chg_valid[d] !== 1'b0 || credit[d] !== '0 || busy[d] !== 1'b0) begin
      n_bad++;
      $display("FAIL chg_done[%0d]: valid=%b credit=%0d busy=%b, want 0/0/0", d, chg_valid[d], credit[d], busy[d]);
    end
  endtask

  // Dispense handshake after an accepted selection; optionally pokes inputs while waiting.
  task automatic finish_vend(input int d, input int s, input int p, input int hold, input bit poke);
    int n = 0;
    int res;
    bit want;
    if (poke) begin
      coin_valid[d] = 1'b1; coin[d] = CW'(10); cancel[d] = 1'b1;
      sel_valid[d] = 1'b1; sel[d] = SW'((s + 1) % NPROD);
      @(negedge clk);
      n++;
      coin_valid[d] = 1'b0; cancel[d] = 1'b0; sel_valid[d] = 1'b0;
      n_cmp++;
      if (coin_reject[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL busy_coin_reject[%0d]: got %b, want 1", d, coin_reject[d]);
      end
      n_cmp++;
      if (busy[d] !== 1'b1 || credit[d] !== CW'(m_credit[d])) begin
        n_bad++;
        $display("FAIL busy_ignore[%0d]: busy=%b credit=%0d, want busy=1 credit=%0d", d, busy[d], credit[d], m_credit[d]);
      end
    end
    while (bev_valid[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != DISP_CYC) begin
      n_bad++;
      $display("FAIL bev_latency[%0d]: got %0d cycles, want %0d", d, n, DISP_CYC);
    end
    for (int i = 0; i <= hold; i++) begin
      n_cmp++;
      if (bev_valid[d] !== 1'b1 || bev[d] !== SW'(s)) begin
        n_bad++;
        $display("FAIL bev_hold[%0d]: valid=%b bev=%0d, want valid=1 bev=%0d", d, bev_valid[d], bev[d], s);
      end
      if (i < hold) @(negedge clk);
    end
    bev_ack[d] = 1'b1;
    @(negedge clk);
    bev_ack[d] = 1'b0;
    res = m_credit[d] - p;
    m_credit[d] = res;
    want = (d == 1) ? (res > 0) : (res > 0 && res < cheapest());
    n_cmp++;
    if (bev_valid[d] !== 1'b0 || credit[d] !== CW'(res) || busy[d] !== want) begin
      n_bad++;
      $display("FAIL bev_done[%0d]: valid=%b credit=%0d busy=%b, want valid=0 credit=%0d busy=%b",
               d, bev_valid[d], credit[d], busy[d], res, want);
    end
    if (want) finish_chg(d, hold);
  endtask

  // One IDLE cycle of customer inputs, then any vend/change flow it starts.
  task automatic step_idle(input int d, input bit cv, input int c, input bit sv, input int s,
                           input bit cn, input int hold, input bit poke);
    bit can_ok, sel_ok, coin_ok;
    int p;
    p       = prices[s];
    can_ok  = cn && (m_credit[d] > 0);
    sel_ok  = !can_ok && sv && (s < NPROD) && (m_credit[d] >= p);
    coin_ok = !can_ok && !sel_ok && cv && is_legal(c) && (m_credit[d] + c <= MAXC);
    if (coin_ok) m_credit[d] += c;
    coin_valid[d] = cv; coin[d] = CW'(c); sel_valid[d] = sv; sel[d] = SW'(s); cancel[d] = cn;
    @(negedge clk);
    coin_valid[d] = 1'b0; sel_valid[d] = 1'b0; cancel[d] = 1'b0;
    n_cmp++;
    if (coin_reject[d] !== (cv && !coin_ok)) begin
      n_bad++;
      $display("FAIL coin_reject[%0d] coin=%0d: got %b, want %b", d, c, coin_reject[d], cv && !coin_ok);
    end
    n_cmp++;
    if (credit[d] !== CW'(m_credit[d]) || busy[d] !== (can_ok || sel_ok)) begin
      n_bad++;
      $display("FAIL idle_step[%0d]: credit=%0d busy=%b, want credit=%0d busy=%b",
               d, credit[d], busy[d], m_credit[d], can_ok || sel_ok);
    end
    if (sel_ok) finish_vend(d, s, p, hold, poke);
    else if (can_ok) finish_chg(d, hold);
  endtask

  task automatic put_coin(input int d, input int c);
    step_idle(d, 1'b1, c, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({coin_reject[d], bev_valid[d], chg_valid[d], busy[d]} !== 4'b0 ||
          credit[d] !== '0 || bev[d] !== '0 || chg[d] !== '0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: rej=%b bev_v=%b chg_v=%b busy=%b credit=%0d, want all 0",
                 d, coin_reject[d], bev_valid[d], chg_valid[d], busy[d], credit[d]);
      end
      m_credit[d] = 0;
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    put_coin(0, 20);
    put_coin(0, 20);
    step_idle(0, 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_no_change();
    for (int d = 0; d < 2; d++) begin
      put_coin(d, 100);
      put_coin(d, 50);
      step_idle(d, 1'b0, 0, 1'b1, 1, 1'b0, 1, 1'b0);
    end
  endtask

  task automatic test_coin_limits();
    step_idle(0, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0);
    put_coin(0, 30);
    put_coin(0, 200);
    put_coin(0, 200);
    put_coin(0, 200);
    put_coin(0, 100);
    put_coin(0, 10);
    step_idle(0, 1'b0, 0, 1'b0, 0, 1'b1, 2, 1'b0);
  endtask

  task automatic test_cancel();
    step_idle(0, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0);
    put_coin(0, 20);
    step_idle(0, 1'b0, 0, 1'b1, 1, 1'b0, 0, 1'b0);
    step_idle(0, 1'b1, 10, 1'b0, 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_busy_inputs();
    put_coin(0, 50);
    put_coin(0, 50);
    step_idle(0, 1'b0, 0, 1'b1, 2, 1'b0, 5, 1'b1);
    step_idle(0, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_free_vend();
    load_prices(30, 50, 70, 0);
    step_idle(0, 1'b0, 0, 1'b1, 3, 1'b0, 0, 1'b0);
    load_prices(30, 50, 70, 100);
  endtask

  task automatic test_random();
    load_prices(10 * $urandom_range(0, 12), 10 * $urandom_range(0, 12),
                10 * $urandom_range(0, 12), 10 * $urandom_range(0, 12));
    for (int k = 0; k < 60; k++) begin
      step_idle($urandom_range(0, 1), 1'($urandom_range(0, 1)), coin_tbl[$urandom_range(0, 9)],
                ($urandom_range(0, 3) == 0), $urandom_range(0, NPROD - 1),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end
    load_prices(30, 50, 70, 100);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    put_coin(0, 50);
    cancel[0] = 1'b1;
    @(negedge clk);
    cancel[0] = 1'b0;
    while (chg_valid[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != CHG_CYC) begin
      n_bad++;
      $display("FAIL mid_chg_latency: got %0d cycles, want %0d", n, CHG_CYC);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_credit = '{0, 0};
    n_cmp++;
    if (chg_valid[0] !== 1'b0 || credit[0] !== '0 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: chg_valid=%b credit=%0d busy=%b, want 0/0/0", chg_valid[0], credit[0], busy[0]);
    end
    put_coin(0, 20);
  endtask

  initial begin
    rst = 1'b0;
    coin_valid = '0; sel_valid = '0; cancel = '0; bev_ack = '0; chg_ack = '0;
    coin = '{default: '0};
    sel  = '{default: '0};
    load_prices(30, 50, 70, 100);
    test_reset();
    test_basic();
    test_no_change();
    test_coin_limits();
    test_cancel();
    test_busy_inputs();
    test_free_vend();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
